fb_scanout_ctl: RTL and testbench

Register-programmable framebuffer scanout controller in the AXI clock domain, between the AXI register slave and the DMA reader / async pixel FIFO. It replaces fixed base-address, burst-count and enable wiring with: NBUF selectable framebuffers and vsync-aligned page flips; burst count derived from programmed geometry; a timed FIFO flush per frame; overrun detection; and an interrupt.

---
 rtl/fb_scanout_ctl_if.sv | 34 +++
 rtl/fb_scanout_ctl.sv | 242 ++++++++++++++++++++++++
 tb/tb_fb_scanout_ctl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/fb_scanout_ctl_if.sv
// fb_scanout_ctl_if
//   Groups the register bus and the scanout-side signals of fb_scanout_ctl.
//   Register side : i_wr, i_wreg, i_wdata (write), i_rreg -> o_rdata (read).
//   Video side    : i_vsync, i_dma_busy in; o_start, o_baseaddr,
//                   o_burst_count, o_fifo_reset, o_pattern, o_irq out.
//   slave  : the controller's view.
//   master : the view of whoever drives the bus and video inputs.
interface fb_scanout_ctl_if;
  logic        i_wr;
  logic [3:0]  i_wreg;
  logic [31:0] i_wdata;
  logic [3:0]  i_rreg;
  logic [31:0] o_rdata;
  logic        i_vsync;
  logic        i_dma_busy;
  logic        o_start;
  logic [31:0] o_baseaddr;
  logic [19:0] o_burst_count;
  logic        o_fifo_reset;
  logic [23:0] o_pattern;
  logic        o_irq;

  modport slave (
    input  i_wr, i_wreg, i_wdata, i_rreg, i_vsync, i_dma_busy,
    output o_rdata, o_start, o_baseaddr, o_burst_count, o_fifo_reset,
           o_pattern, o_irq
  );

  modport master (
    output i_wr, i_wreg, i_wdata, i_rreg, i_vsync, i_dma_busy,
    input  o_rdata, o_start, o_baseaddr, o_burst_count, o_fifo_reset,
           o_pattern, o_irq
  );
endinterface

// File: rtl/fb_scanout_ctl.sv
// fb_scanout_ctl
//   Register-programmable framebuffer scanout controller. Selects one of NBUF
//   framebuffers (page flips take effect on a vsync rising edge), derives the
//   DMA burst count from the programmed geometry, flushes the pixel FIFO at the
//   start of each frame, starts the DMA, flags frame-done / overrun and raises
//   a level interrupt.
//   Ports: clk, reset (async, active-high), bus (fb_scanout_ctl_if.slave).
//   Optional build macro SCANOUT_STATS_EN adds saturating frame / overrun
//   counters readable at register 10; without it register 10 reads zero.
module fb_scanout_ctl #(
  parameter int NBUF         = 2,
  parameter int BURST_BYTES  = 64,
  parameter int FLUSH_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  fb_scanout_ctl_if.slave   bus
);
  localparam int          BURST_SH = $clog2(BURST_BYTES);
  localparam logic [2:0]  NBUF_W   = 3'(NBUF);
  localparam logic [3:0]  FLUSH_LD = 4'(FLUSH_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_FLUSH, S_START, S_RUN} state_t;

  state_t      state_q, state_d;
  logic        enable_q, enable_d, irq_en_q, irq_en_d;
  logic [23:0] pattern_q, pattern_d;
  logic [11:0] width_q, width_d, height_q, height_d;
  logic [31:0] base_q [4];
  logic [31:0] base_d [4];
  logic [1:0]  req_q, req_d, active_q, active_d;
  logic        pending_q, pending_d, overrun_q, overrun_d, done_q, done_d;
  logic        vsync_q, fifo_reset_q, fifo_reset_d, start_q, start_d;
  logic        run_first_q, run_first_d;
  logic [3:0]  flush_cnt_q, flush_cnt_d;
  logic [19:0] burst_q, burst_d;
  logic [25:0] frame_bytes, frame_rounded;
  logic        vs_edge, set_done, set_ovr;
  logic [31:0] stats_rdata;

  // Geometry product fits 26 bits even at 4095x4095x4 plus rounding.
  assign frame_bytes   = ({14'd0, width_q} * {14'd0, height_q}) << 2;
  assign frame_rounded = frame_bytes + 26'(BURST_BYTES - 1);
  assign burst_d       = 20'(frame_rounded >> BURST_SH);
  assign vs_edge       = bus.i_vsync & ~vsync_q;

`ifdef SCANOUT_STATS_EN
  logic [15:0] frame_cnt_q, frame_cnt_d, ovr_cnt_q, ovr_cnt_d;
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    ovr_cnt_d   = ovr_cnt_q;
    if (bus.i_wr && bus.i_wreg == 4'd10) begin
      frame_cnt_d = 16'd0;
      ovr_cnt_d   = 16'd0;
    end
    if (set_done && frame_cnt_d != 16'hFFFF) frame_cnt_d = frame_cnt_d + 16'd1;
    if (set_ovr && ovr_cnt_d != 16'hFFFF)     ovr_cnt_d   = ovr_cnt_d + 16'd1;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt_q <= 16'd0;
      ovr_cnt_q   <= 16'd0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      ovr_cnt_q   <= ovr_cnt_d;
    end
  end
  assign stats_rdata = {ovr_cnt_q, frame_cnt_q};
`else
  assign stats_rdata = 32'h0;
`endif

  always_comb begin
    state_d      = state_q;
    enable_d     = enable_q;
    irq_en_d     = irq_en_q;
    pattern_d    = pattern_q;
    width_d      = width_q;
    height_d     = height_q;
    base_d       = base_q;
    req_d        = req_q;
    active_d     = active_q;
    pending_d    = pending_q;
    overrun_d    = overrun_q;
    done_d       = done_q;
    fifo_reset_d = fifo_reset_q;
    flush_cnt_d  = flush_cnt_q;
    run_first_d  = run_first_q;
    start_d      = 1'b0;
    set_done     = 1'b0;
    set_ovr      = 1'b0;

    if (bus.i_wr) begin
      case (bus.i_wreg)
        4'd0: begin
          enable_d = bus.i_wdata[0];
          irq_en_d = bus.i_wdata[1];
        end
        4'd2: pattern_d = bus.i_wdata[23:0];
        4'd3: begin
          width_d  = bus.i_wdata[11:0];
          height_d = bus.i_wdata[27:16];
        end
        default: ;
      endcase
      for (int n = 0; n < 4; n++)
        if (n < NBUF && bus.i_wreg == 4'(4 + n)) base_d[n] = bus.i_wdata;
    end

    // A forced flush in IDLE/WAIT counts down without changing state.
    if ((state_q == S_IDLE || state_q == S_WAIT) && fifo_reset_q) begin
      if (flush_cnt_q == 4'd0) fifo_reset_d = 1'b0;
      else                     flush_cnt_d  = flush_cnt_q - 4'd1;
    end
    if (bus.i_wr && bus.i_wreg == 4'd0 && bus.i_wdata[2] &&
        (state_q == S_IDLE || state_q == S_WAIT)) begin
      fifo_reset_d = 1'b1;
      flush_cnt_d  = FLUSH_LD;
    end

    if (!enable_q && state_q != S_IDLE) begin
      state_d = S_IDLE;
      if (state_q != S_WAIT) fifo_reset_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (enable_q) state_d = S_WAIT;
        S_WAIT: if (vs_edge) begin
          if (pending_q) begin
            active_d  = req_q;
            pending_d = 1'b0;
          end
          fifo_reset_d = 1'b1;
          flush_cnt_d  = FLUSH_LD;
          state_d      = S_FLUSH;
        end
        S_FLUSH: begin
          set_ovr = vs_edge;
          if (flush_cnt_q == 4'd0) begin
            fifo_reset_d = 1'b0;
            start_d      = 1'b1;
            state_d      = S_START;
          end else begin
            flush_cnt_d = flush_cnt_q - 4'd1;
          end
        end
        S_START: begin
          run_first_d = 1'b1;
          state_d     = S_RUN;
        end
        S_RUN: begin
          set_ovr     = vs_edge;
          run_first_d = 1'b0;
          // Busy is not trusted on the first RUN cycle: the DMA may not
          // have seen the start pulse yet.
          if (!run_first_q && !bus.i_dma_busy) begin
            set_done = 1'b1;
            state_d  = S_WAIT;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Evaluated after the vsync flip so a same-cycle FLIP waits a frame.
    if (bus.i_wr && bus.i_wreg == 4'd8 && {1'b0, bus.i_wdata[1:0]} < NBUF_W) begin
      req_d     = bus.i_wdata[1:0];
      pending_d = 1'b1;
    end

    // Clear first so a coincident set wins.
    if (bus.i_wr && bus.i_wreg == 4'd9) begin
      if (bus.i_wdata[3]) overrun_d = 1'b0;
      if (bus.i_wdata[4]) done_d    = 1'b0;
    end
    if (set_ovr)  overrun_d = 1'b1;
    if (set_done) done_d    = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      enable_q     <= 1'b0;
      irq_en_q     <= 1'b0;
      pattern_q    <= 24'd0;
      width_q      <= 12'd0;
      height_q     <= 12'd0;
      for (int n = 0; n < 4; n++) base_q[n] <= 32'd0;
      req_q        <= 2'd0;
      active_q     <= 2'd0;
      pending_q    <= 1'b0;
      overrun_q    <= 1'b0;
      done_q       <= 1'b0;
      vsync_q      <= 1'b0;
      fifo_reset_q <= 1'b0;
      flush_cnt_q  <= 4'd0;
      run_first_q  <= 1'b0;
      start_q      <= 1'b0;
      burst_q      <= 20'd0;
    end else begin
      state_q      <= state_d;
      enable_q     <= enable_d;
      irq_en_q     <= irq_en_d;
      pattern_q    <= pattern_d;
      width_q      <= width_d;
      height_q     <= height_d;
      base_q       <= base_d;
      req_q        <= req_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      overrun_q    <= overrun_d;
      done_q       <= done_d;
      vsync_q      <= bus.i_vsync;
      fifo_reset_q <= fifo_reset_d;
      flush_cnt_q  <= flush_cnt_d;
      run_first_q  <= run_first_d;
      start_q      <= start_d;
      burst_q      <= burst_d;
    end
  end

  always_comb begin
    bus.o_rdata = 32'h0;
    case (bus.i_rreg)
      4'd0:  bus.o_rdata = {30'd0, irq_en_q, enable_q};
      4'd1:  bus.o_rdata = {26'd0, enable_q, done_q, overrun_q, pending_q, active_q};
      4'd2:  bus.o_rdata = {8'd0, pattern_q};
      4'd3:  bus.o_rdata = {4'd0, height_q, 4'd0, width_q};
      4'd8:  bus.o_rdata = {30'd0, req_q};
      4'd10: bus.o_rdata = stats_rdata;
      default: ;
    endcase
    for (int n = 0; n < 4; n++)
      if (n < NBUF && bus.i_rreg == 4'(4 + n)) bus.o_rdata = base_q[n];
  end

  assign bus.o_start       = start_q;
  assign bus.o_baseaddr    = base_q[active_q];
  assign bus.o_burst_count = burst_q;
  assign bus.o_fifo_reset  = fifo_reset_q;
  assign bus.o_pattern     = pattern_q;
  assign bus.o_irq         = irq_en_q & (done_q | overrun_q);
endmodule

// File: tb/tb_fb_scanout_ctl.sv
// Directed testbench for fb_scanout_ctl (NBUF=2, BURST_BYTES=64, FLUSH_CYCLES=4).
module tb_fb_scanout_ctl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  logic [31:0] rv;

  fb_scanout_ctl_if bus();

  fb_scanout_ctl #(.NBUF(2), .BURST_BYTES(64), .FLUSH_CYCLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] r, input logic [31:0] d);
    bus.i_wr = 1'b1;
    bus.i_wreg = r;
    bus.i_wdata = d;
    tick();
    bus.i_wr = 1'b0;
    $display("write reg%0d <= %08h", r, d);
  endtask

  task automatic rd(input logic [3:0] r, output logic [31:0] d);
    bus.i_rreg = r;
    #1;
    d = bus.o_rdata;
    $display("read  reg%0d -> %08h", r, d);
  endtask

  // Call with the FSM in WAIT and vsync low for at least one cycle.
  // Returns on the first RUN cycle with vsync low again.
  task automatic run_frame(input logic [31:0] exp_base);
    bus.i_vsync = 1'b1;
    bus.i_dma_busy = 1'b1;
    tick();
    check("frame_base", bus.o_baseaddr, exp_base);
    for (int i = 0; i < 4; i++) begin
      check("flush_phase", {30'd0, bus.o_fifo_reset, bus.o_start}, 32'h2);
      tick();
    end
    check("start_pulse", {30'd0, bus.o_fifo_reset, bus.o_start}, 32'h1);
    tick();
    bus.i_vsync = 1'b0;
    check("start_one_cycle", {31'd0, bus.o_start}, 32'h0);
    $display("frame started base=%08h", exp_base);
  endtask

  task automatic end_frame();
    bus.i_dma_busy = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    bus.i_wr = 1'b0;
    bus.i_wreg = 4'd0;
    bus.i_wdata = 32'd0;
    bus.i_rreg = 4'd0;
    bus.i_vsync = 1'b0;
    bus.i_dma_busy = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset state
    check("rst_start", {31'd0, bus.o_start}, 32'h0);
    check("rst_fifo_reset", {31'd0, bus.o_fifo_reset}, 32'h0);
    check("rst_irq", {31'd0, bus.o_irq}, 32'h0);
    check("rst_pattern", {8'd0, bus.o_pattern}, 32'h0);
    check("rst_burst", {12'd0, bus.o_burst_count}, 32'h0);
    check("rst_base", bus.o_baseaddr, 32'h0);
    rd(4'd1, rv); check("rst_status", rv, 32'h0);

    // Geometry: 960x600x4 / 64 = 36000 bursts, two cycles after the write
    wr(4'd3, {4'd0, 12'd600, 4'd0, 12'd960});
    check("burst_latency", {12'd0, bus.o_burst_count}, 32'h0);
    rd(4'd3, rv); check("size_read", rv, 32'h0258_03C0);
    tick();
    check("burst_count", {12'd0, bus.o_burst_count}, 32'd36000);
    check("geom_no_start", {31'd0, bus.o_start}, 32'h0);
    wr(4'd2, 32'hFF12_3456);
    check("pattern", {8'd0, bus.o_pattern}, 32'h0012_3456);
    rd(4'd12, rv); check("unmapped_read", rv, 32'h0);
    wr(4'd6, 32'hDEAD_BEEF);
    rd(4'd6, rv); check("base_beyond_nbuf", rv, 32'h0);

    // First frame
    wr(4'd4, 32'h1000_0000);
    check("base0_out", bus.o_baseaddr, 32'h1000_0000);
    wr(4'd0, 32'h1);
    tick();
    run_frame(32'h1000_0000);
    rd(4'd1, rv); check("status_run", rv, 32'h20);

    // Page flip requested mid-frame; out-of-range flip ignored
    wr(4'd5, 32'h1040_0000);
    wr(4'd8, 32'h3);
    rd(4'd1, rv); check("flip3_ignored", rv, 32'h20);
    wr(4'd8, 32'h1);
    rd(4'd1, rv); check("flip_pending", rv, 32'h24);
    check("base_stable", bus.o_baseaddr, 32'h1000_0000);
    end_frame();
    rd(4'd1, rv); check("frame_done", rv, 32'h34);
    run_frame(32'h1040_0000);
    rd(4'd1, rv); check("flip_applied", rv, 32'h31);

    // Overrun: vsync while DMA still busy
    wr(4'd9, 32'h10);
    wr(4'd0, 32'h3);
    check("irq_clear", {31'd0, bus.o_irq}, 32'h0);
    bus.i_vsync = 1'b1;
    tick();
    check("irq_overrun", {31'd0, bus.o_irq}, 32'h1);
    rd(4'd1, rv); check("status_overrun", rv, 32'h29);
    for (int i = 0; i < 6; i++) begin
      check("no_restart", {31'd0, bus.o_start}, 32'h0);
      tick();
    end
    bus.i_vsync = 1'b0;
    wr(4'd9, 32'h8);
    check("irq_acked", {31'd0, bus.o_irq}, 32'h0);
    rd(4'd1, rv); check("status_acked", rv, 32'h21);
    end_frame();
    check("irq_done", {31'd0, bus.o_irq}, 32'h1);
    run_frame(32'h1040_0000);
    end_frame();
    wr(4'd9, 32'h18);
    check("irq_all_acked", {31'd0, bus.o_irq}, 32'h0);

    // Stats: 3 frames completed, 1 overrun
    rd(4'd10, rv);
`ifdef SCANOUT_STATS_EN
    check("stats", rv, 32'h0001_0003);
    wr(4'd10, 32'h0);
    rd(4'd10, rv); check("stats_cleared", rv, 32'h0);
`else
    check("stats_absent", rv, 32'h0);
`endif

    // Disable during RUN
    run_frame(32'h1040_0000);
    wr(4'd0, 32'h0);
    tick();
    rd(4'd1, rv); check("status_disabled", rv, 32'h1);
    bus.i_dma_busy = 1'b0;
    for (int i = 0; i < 12; i++) begin
      bus.i_vsync = (i % 4) < 2;
      tick();
      check("idle_no_start", {30'd0, bus.o_fifo_reset, bus.o_start}, 32'h0);
    end
    bus.i_vsync = 1'b0;

    // Forced flush while idle
    wr(4'd0, 32'h4);
    for (int i = 0; i < 4; i++) begin
      check("forced_flush", {30'd0, bus.o_fifo_reset, bus.o_start}, 32'h2);
      tick();
    end
    check("forced_flush_end", {31'd0, bus.o_fifo_reset}, 32'h0);
    rd(4'd1, rv); check("forced_flush_idle", rv, 32'h1);

    // Asynchronous reset mid-frame
    wr(4'd0, 32'h1);
    tick();
    tick();
    bus.i_vsync = 1'b1;
    tick();
    check("pre_reset_flush", {31'd0, bus.o_fifo_reset}, 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check("async_fifo_reset", {31'd0, bus.o_fifo_reset}, 32'h0);
    check("async_base", bus.o_baseaddr, 32'h0);
    check("async_pattern", {8'd0, bus.o_pattern}, 32'h0);
    check("async_burst", {12'd0, bus.o_burst_count}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
